// File: rtl/round_controller.sv
// round_controller: game sequencer that walks each round through generate, show, input and settle,
// counts rounds and correct answers, drives the active-low stage reset and computes the final score.
module round_controller #(
   parameter int unsigned NUM_ROUNDS    = 10,
   parameter int unsigned POINTS        = 10,
   parameter int unsigned SETTLE_CYC    = 3,
   parameter int unsigned RRST_CYC      = 2,
   parameter int unsigned GAP_CYC       = 500,
   parameter int unsigned INPUT_TIMEOUT = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] level,
   input  logic       gen_done,
   input  logic       print_done,
   input  logic       trim_done,
   input  logic       round_win,
   output logic [2:0] level_q,
   output logic       gen_start,
   output logic       round_rst,
   output logic [4:0] round_count,
   output logic [3:0] answer_count,
   output logic [6:0] score,
   output logic       game_end,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GEN    = 3'd1,
      S_SHOW   = 3'd2,
      S_INPUT  = 3'd3,
      S_SETTLE = 3'd4,
      S_RRST   = 3'd5,
      S_GAP    = 3'd6,
      S_DONE   = 3'd7
   } state_e;

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
   localparam logic [15:0] RRST_LAST   = 16'(RRST_CYC - 1);
   localparam logic [15:0] GAP_LAST    = (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);
   localparam logic [15:0] TMO_LAST    = (INPUT_TIMEOUT == 0) ? 16'd0 : 16'(INPUT_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        lost_q, lost_d;
   logic [2:0]  lvl_q, lvl_d;
   logic [4:0]  rnd_q, rnd_d;
   logic [3:0]  ans_q, ans_d;
   logic [6:0]  score_q, score_d;
   logic        gen_start_q, gen_start_d;
   logic [4:0]  rnd_new;
   logic [3:0]  ans_new;
   logic        level_valid;

   assign level_valid = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lost_d      = lost_q;
      lvl_d       = lvl_q;
      rnd_d       = rnd_q;
      ans_d       = ans_q;
      score_d     = score_q;
      gen_start_d = 1'b0;
      rnd_new     = (rnd_q == '1) ? rnd_q : rnd_q + 5'd1;
      ans_new     = (round_win && !lost_q && (ans_q != '1)) ? ans_q + 4'd1 : ans_q;

      // cnt is cleared on every state change so each state starts counting from zero
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && level_valid) begin
               lvl_d       = level;
               rnd_d       = '0;
               ans_d       = '0;
               score_d     = '0;
               gen_start_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_GEN;
            end
         end
         S_GEN: begin
            if (gen_done) begin
               cnt_d   = '0;
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            cnt_d = '0;
            if (print_done) state_d = S_INPUT;
         end
         S_INPUT: begin
            if (trim_done) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else if ((INPUT_TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
               lost_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else if (INPUT_TIMEOUT != 0) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d  = '0;
               lost_d = 1'b0;
               rnd_d  = rnd_new;
               ans_d  = ans_new;
               if (rnd_new == 5'(NUM_ROUNDS)) begin
                  score_d = 7'(POINTS * ans_new);
                  state_d = S_DONE;
               end else begin
                  state_d = S_RRST;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RRST: begin
            if (cnt_q == RRST_LAST) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d       = '0;
               gen_start_d = 1'b1;
               state_d     = S_GEN;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lost_q      <= 1'b0;
         lvl_q       <= '0;
         rnd_q       <= '0;
         ans_q       <= '0;
         score_q     <= '0;
         gen_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lost_q      <= lost_d;
         lvl_q       <= lvl_d;
         rnd_q       <= rnd_d;
         ans_q       <= ans_d;
         score_q     <= score_d;
         gen_start_q <= gen_start_d;
      end
   end

   assign level_q      = lvl_q;
   assign gen_start    = gen_start_q;
   assign round_count  = rnd_q;
   assign answer_count = ans_q;
   assign score        = score_q;
   assign state_o      = state_q;
   assign game_end     = (state_q == S_DONE);
   assign round_rst    = (state_q == S_GEN) || (state_q == S_SHOW) || (state_q == S_INPUT) ||
                         (state_q == S_SETTLE) || (state_q == S_GAP);

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: the bench plays the round stages, predicting each round's
// timing and outcome from the game rules (win counted only if round_win on the sample cycle and no timeout).
module tb_round_controller;

   localparam int unsigned NR  = 10;
   localparam int unsigned PTS = 10;
   localparam int unsigned SET = 3;
   localparam int unsigned RR  = 2;
   localparam int unsigned GAP = 6;
   localparam int unsigned TMO = 20;

   localparam int S_IDLE = 0, S_GEN = 1, S_SHOW = 2, S_INPUT = 3, S_SETTLE = 4,
                  S_RRST = 5, S_GAP = 6, S_DONE = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] level = 3'b000;
   logic       gen_done = 1'b0, print_done = 1'b0, trim_done = 1'b0, round_win = 1'b0;
   logic [2:0] level_q, state_o;
   logic       gen_start, round_rst, game_end;
   logic [4:0] round_count;
   logic [3:0] answer_count;
   logic [6:0] score;

   int total = 0;
   int bad = 0;
   int exp_rounds = 0;
   int exp_wins = 0;
   int cur_round = 0;
   logic [2:0] exp_level = 3'b000;

   typedef struct {
      logic       st;
      logic [2:0] lv;
      logic       go;
   } vec_t;
   vec_t tbl[10];

   round_controller #(
      .NUM_ROUNDS(NR), .POINTS(PTS), .SETTLE_CYC(SET),
      .RRST_CYC(RR), .GAP_CYC(GAP), .INPUT_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .level(level),
      .gen_done(gen_done), .print_done(print_done), .trim_done(trim_done), .round_win(round_win),
      .level_q(level_q), .gen_start(gen_start), .round_rst(round_rst),
      .round_count(round_count), .answer_count(answer_count), .score(score),
      .game_end(game_end), .state_o(state_o)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s (round %0d): got %0d required %0d", name, cur_round, act, exp);
      end
   endtask

   function automatic logic [2:0] rand_lv();
      logic [2:0] v;
      v = 3'b001 << $urandom_range(0, 2);
      return v;
   endfunction

   // start/level noise mid-game: must never restart the game
   task automatic noise();
      start = 1'($urandom_range(0, 1));
      level = rand_lv();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, state_o, S_IDLE);
      chk({tag, "_level_q"}, level_q, 0);
      chk({tag, "_gen_start"}, gen_start, 0);
      chk({tag, "_round_rst"}, round_rst, 0);
      chk({tag, "_round_count"}, round_count, 0);
      chk({tag, "_answer_count"}, answer_count, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_game_end"}, game_end, 0);
   endtask

   task automatic start_game(input logic [2:0] lv);
      start = 1'b1;
      level = lv;
      tick();
      start = 1'b0;
      exp_level = lv;
      exp_rounds = 0;
      exp_wins = 0;
      cur_round = 1;
      chk("start_state", state_o, S_GEN);
      chk("start_gen_pulse", gen_start, 1);
      chk("start_level_q", level_q, lv);
      chk("start_round_count", round_count, 0);
      chk("start_answer_count", answer_count, 0);
      chk("start_score", score, 0);
      chk("start_game_end", game_end, 0);
      chk("start_round_rst", round_rst, 1);
   endtask

   // Precondition: first GEN cycle of round cur_round has just begun.
   task automatic run_round(input int gd, input int pd, input int td, input bit win, input bit abort);
      bit lost;
      int n_in;
      for (int i = 0; i <= gd; i++) begin
         gen_done = (i == gd);
         print_done = 1'($urandom_range(0, 1));
         trim_done = 1'($urandom_range(0, 1));
         noise();
         tick();
         if (i < gd) begin
            chk("gen_wait_state", state_o, S_GEN);
            chk("gen_pulse_once", gen_start, 0);
         end
      end
      chk("gen_to_show", state_o, S_SHOW);
      chk("show_round_rst", round_rst, 1);
      for (int i = 0; i <= pd; i++) begin
         print_done = (i == pd);
         trim_done = 1'($urandom_range(0, 1));
         noise();
         tick();
         if (i < pd) chk("show_wait_state", state_o, S_SHOW);
      end
      chk("show_to_input", state_o, S_INPUT);
      if (abort) begin
         trim_done = 1'b0;
         start = 1'b0;
         tick();
         chk("abort_in_input", state_o, S_INPUT);
         rst = 1'b0;
         tick();
         rst = 1'b1;
         chk_reset("midround_reset");
         gen_done = 1'b0;
         print_done = 1'b0;
         return;
      end
      lost = (td >= int'(TMO));
      n_in = lost ? int'(TMO) : td + 1;
      for (int i = 0; i < n_in; i++) begin
         trim_done = (i == td);
         noise();
         tick();
         if (i < n_in - 1) chk("input_wait_state", state_o, S_INPUT);
      end
      chk("input_to_settle", state_o, S_SETTLE);
      for (int i = 0; i < int'(SET); i++) begin
         round_win = (i == int'(SET) - 1) ? win : ~win;
         noise();
         tick();
         if (i < int'(SET) - 1) begin
            chk("settle_wait_state", state_o, S_SETTLE);
            chk("settle_round_count_held", round_count, exp_rounds);
         end
      end
      round_win = 1'b0;
      start = 1'b0;
      exp_rounds++;
      if (win && !lost) exp_wins++;
      chk("round_count", round_count, exp_rounds);
      chk("answer_count", answer_count, exp_wins);
      chk("level_q_held", level_q, exp_level);
      if (exp_rounds == int'(NR)) begin
         chk("done_state", state_o, S_DONE);
         chk("done_game_end", game_end, 1);
         chk("done_round_rst", round_rst, 0);
         chk("done_score", score, int'(PTS) * exp_wins);
         gen_done = 1'b0;
         print_done = 1'b0;
         trim_done = 1'b0;
         return;
      end
      chk("rrst_state", state_o, S_RRST);
      chk("rrst_round_rst", round_rst, 0);
      chk("midgame_score", score, 0);
      gen_done = 1'b0;
      print_done = 1'b0;
      trim_done = 1'b0;
      for (int i = 0; i < int'(RR); i++) begin
         noise();
         tick();
         if (i < int'(RR) - 1) begin
            chk("rrst_hold_state", state_o, S_RRST);
            chk("rrst_hold_low", round_rst, 0);
         end
      end
      chk("gap_state", state_o, S_GAP);
      chk("gap_round_rst", round_rst, 1);
      for (int i = 0; i < int'(GAP); i++) begin
         noise();
         tick();
         if (i < int'(GAP) - 1) begin
            chk("gap_hold_state", state_o, S_GAP);
            chk("gap_no_pulse", gen_start, 0);
         end
      end
      start = 1'b0;
      cur_round++;
      chk("next_gen_state", state_o, S_GEN);
      chk("next_gen_pulse", gen_start, 1);
   endtask

   // mode 0: all won, mode 1: won on rounds 1/3/5, mode 2: every round times out, mode 3: random
   task automatic play_rounds(input int first, input int last, input int mode);
      int gd, pd, td;
      bit win;
      for (int r = first; r <= last; r++) begin
         gd = 1; pd = 1; td = 1; win = 1'b1;
         case (mode)
            1: win = (r == 1) || (r == 3) || (r == 5);
            2: td = int'(TMO) + int'($urandom_range(0, 4));
            3: begin
               gd = int'($urandom_range(0, 3));
               pd = int'($urandom_range(0, 3));
               td = int'($urandom_range(0, TMO + 4));
               win = 1'($urandom_range(0, 1));
            end
            default: ;
         endcase
         run_round(gd, pd, td, win, 1'b0);
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 3'b011, 1'b0};
      tbl[1] = '{1'b1, 3'b000, 1'b0};
      tbl[2] = '{1'b1, 3'b111, 1'b0};
      tbl[3] = '{1'b1, 3'b110, 1'b0};
      tbl[4] = '{1'b1, 3'b101, 1'b0};
      tbl[5] = '{1'b0, 3'b010, 1'b0};
      tbl[6] = '{1'b1, 3'b100, 1'b1};
      tbl[7] = '{1'b1, 3'b001, 1'b1};
      tbl[8] = '{1'b1, 3'b010, 1'b1};
      tbl[9] = '{1'b0, 3'b001, 1'b0};

      tick();
      tick();
      chk_reset("reset");
      rst = 1'b1;
      tick();
      chk("idle_after_release", state_o, S_IDLE);

      foreach (tbl[k]) begin
         start = tbl[k].st;
         level = tbl[k].lv;
         tick();
         start = 1'b0;
         chk("tbl_state", state_o, tbl[k].go ? S_GEN : S_IDLE);
         chk("tbl_gen_start", gen_start, int'(tbl[k].go));
         chk("tbl_level_q", level_q, tbl[k].go ? int'(tbl[k].lv) : 0);
         chk("tbl_round_rst", round_rst, int'(tbl[k].go));
         if (tbl[k].go) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
            chk_reset("tbl_reset");
         end
      end

      start_game(3'b010);
      play_rounds(1, int'(NR), 0);

      for (int i = 0; i < 4; i++) begin
         start = (i != 3);
         level = (i == 0) ? 3'b011 : (i == 1) ? 3'b000 : 3'b111;
         if (i == 3) level = 3'b001;
         tick();
         chk("done_hold_state", state_o, S_DONE);
         chk("done_hold_round_count", round_count, int'(NR));
         chk("done_hold_score", score, int'(PTS) * int'(NR));
         chk("done_hold_gen_start", gen_start, 0);
      end
      start = 1'b0;

      start_game(3'b100);
      play_rounds(1, int'(NR), 1);

      start_game(3'b001);
      play_rounds(1, int'(NR), 2);

      start_game(3'b010);
      play_rounds(1, 3, 3);
      run_round(1, 1, 1, 1'b1, 1'b1);
      tick();
      chk("idle_after_midround_reset", state_o, S_IDLE);
      start_game(rand_lv());
      play_rounds(1, int'(NR), 3);

      for (int g = 0; g < 3; g++) begin
         start_game(rand_lv());
         play_rounds(1, int'(NR), 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
